obi_mem_adapter: RTL and testbench

OBI slave front-end that sits directly upstream of the word-aligned 32-bit data/instruction memory.
- Accepts OBI request-channel transactions (req/gnt).
- Translates the OBI byte-enable and address into the memory's lane-addressed be/a convention.
- Performs an address range check.
- Buffers memory responses in a small response FIFO, returned on the OBI response channel (rvalid/rready).
- Provides a one-cycle response latency to the core's LSU/IF.

---
 rtl/obi_mem_adapter_if.sv | 42 ++++
 rtl/obi_mem_adapter.sv | 85 ++++++++
 tb/tb_obi_mem_adapter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obi_mem_adapter_if.sv
// rtl/obi_mem_adapter_if.sv - OBI request/response and memory-side signal bundle (OBI_RREADY_EN adds obi_rready_i)
interface obi_mem_adapter_if;
    logic        obi_req_i;
    logic        obi_gnt_o;
    logic [31:0] obi_addr_i;
    logic        obi_we_i;
    logic [3:0]  obi_be_i;
    logic [31:0] obi_wdata_i;
    logic        obi_rvalid_o;
`ifdef OBI_RREADY_EN
    logic        obi_rready_i;
`endif
    logic [31:0] obi_rdata_o;
    logic        obi_err_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_a_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_err_i;

    // Adapter view: OBI slave towards the core, master towards the memory.
    modport slave (
        input  obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
        output obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
        output mem_we_o, mem_be_o, mem_a_o, mem_wd_o,
        input  mem_rd_i, mem_err_i
`ifdef OBI_RREADY_EN
        , input obi_rready_i
`endif
    );

    modport master (
        output obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
        input  obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
        input  mem_we_o, mem_be_o, mem_a_o, mem_wd_o,
        output mem_rd_i, mem_err_i
`ifdef OBI_RREADY_EN
        , output obi_rready_i
`endif
    );
endinterface

// File: rtl/obi_mem_adapter.sv
// rtl/obi_mem_adapter.sv - OBI slave front-end for word-aligned memory with in-order response FIFO (OBI_RREADY_EN enables rready backpressure)
module obi_mem_adapter #(
    parameter int MEM_WIDTH = 6,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    obi_mem_adapter_if.slave  bus
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);

    logic [31:0]          fifo_rdata [RSP_DEPTH];
    logic [RSP_DEPTH-1:0] fifo_err;
    logic [PW-1:0]        wptr, rptr;
    logic [CW-1:0]        count;
    logic                 rready, accept, pop, range_err, rsp_err, rvalid;
    logic [1:0]           lane;
    logic [31:0]          rsp_rdata;

`ifdef OBI_RREADY_EN
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
    assign rready        = bus.obi_rready_i;
    // Grant looks only at the registered count, so a same-cycle pop never frees a slot.
    assign bus.obi_gnt_o = bus.obi_req_i && (count < DEPTH_C);
`else
    // Responses always drain in their valid cycle, so there is always room.
    assign rready        = 1'b1;
    assign bus.obi_gnt_o = bus.obi_req_i;
`endif

    always_comb begin
        case (bus.obi_be_i)
            4'b0010:          lane = 2'b01;
            4'b1100, 4'b0100: lane = 2'b10;
            4'b1000:          lane = 2'b11;
            default:          lane = 2'b00;
        endcase
    end

    assign range_err    = |bus.obi_addr_i[31:MEM_WIDTH+2];
    assign accept       = bus.obi_req_i && bus.obi_gnt_o;
    assign bus.mem_a_o  = {bus.obi_addr_i[31:2], lane};
    assign bus.mem_be_o = bus.obi_be_i;
    assign bus.mem_wd_o = bus.obi_wdata_i;
    assign bus.mem_we_o = accept && bus.obi_we_i && !range_err;

    assign rsp_err   = range_err | bus.mem_err_i;
    assign rsp_rdata = range_err   ? 32'hDEAD_BEEF :
                       bus.obi_we_i ? 32'h0 : bus.mem_rd_i;

    assign rvalid = (count != '0);
    assign pop    = rvalid && rready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (accept)
                wptr <= (wptr == LAST_PTR) ? '0 : wptr + 1'b1;
            if (pop)
                rptr <= (rptr == LAST_PTR) ? '0 : rptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: the head is masked by rvalid on the way out.
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_rdata[wptr] <= rsp_rdata;
            fifo_err[wptr]   <= rsp_err;
        end
    end

    assign bus.obi_rvalid_o = rvalid;
    assign bus.obi_rdata_o  = rvalid ? fifo_rdata[rptr] : 32'h0;
    assign bus.obi_err_o    = rvalid && fifo_err[rptr];
endmodule

// File: tb/tb_obi_mem_adapter.sv
// tb/tb_obi_mem_adapter.sv - scoreboard bench for obi_mem_adapter with a behavioural lane-addressed memory
`timescale 1ns/1ps
module tb_obi_mem_adapter;
    localparam int MEM_WIDTH = 6;
    localparam int RSP_DEPTH = 2;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    obi_mem_adapter_if bus ();

    obi_mem_adapter #(.MEM_WIDTH(MEM_WIDTH), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    rsp_t        sb [$];
    logic        rready_eff;
    logic        g_we;
    logic [31:0] g_a;

`ifdef OBI_RREADY_EN
    assign rready_eff = bus.obi_rready_i;
`else
    assign rready_eff = 1'b1;
`endif

    function automatic logic be_legal(input logic [3:0] be);
        case (be)
            4'b1111, 4'b0011, 4'b0001, 4'b0010, 4'b1100, 4'b0100, 4'b1000: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Memory: combinational read, byte-lane write, DEADBEEF on be-decode error.
    assign bus.mem_err_i = !be_legal(bus.mem_be_o);
    assign bus.mem_rd_i  = bus.mem_err_i ? 32'hDEAD_BEEF : mem[bus.mem_a_o[7:2]];

    always @(posedge clk) begin
        if (bus.mem_we_o && be_legal(bus.mem_be_o))
            for (int i = 0; i < 4; i++)
                if (bus.mem_be_o[i]) mem[bus.mem_a_o[7:2]][8*i +: 8] <= bus.mem_wd_o[8*i +: 8];
    end

    task automatic model(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, output rsp_t r);
        int idx;
        idx = int'(addr[7:2]);
        if (addr[31:8] != 24'h0) begin
            r.rdata = 32'hDEAD_BEEF;
            r.err   = 1'b1;
        end else begin
            r.err   = !be_legal(be);
            r.rdata = we ? 32'h0 : (be_legal(be) ? ref_mem[idx] : 32'hDEAD_BEEF);
            if (we && be_legal(be))
                for (int i = 0; i < 4; i++)
                    if (be[i]) ref_mem[idx][8*i +: 8] = wd[8*i +: 8];
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus.obi_rvalid_o && rready_eff) begin
            rsp_t exp;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL rsp_unexpected: got rdata=%h err=%b with empty scoreboard", bus.obi_rdata_o, bus.obi_err_o);
            end else begin
                exp = sb.pop_front();
                if ({bus.obi_rdata_o, bus.obi_err_o} !== exp) begin
                    fails++;
                    $display("FAIL rsp_data: got rdata=%h err=%b want rdata=%h err=%b",
                             bus.obi_rdata_o, bus.obi_err_o, exp.rdata, exp.err);
                end
            end
        end
    end

    // Called at posedge+2; returns at posedge+2 right after the accepting edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        rsp_t r;
        bit   done = 1'b0;
        bus.obi_req_i = 1'b1; bus.obi_we_i = we; bus.obi_addr_i = addr;
        bus.obi_be_i  = be;   bus.obi_wdata_i = wd;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (bus.obi_gnt_o) begin
                g_a  = bus.mem_a_o;
                g_we = bus.mem_we_o;
                model(we, addr, be, wd, r);
                sb.push_back(r);
                done = 1'b1;
            end
            @(posedge clk); #2;
        end
        bus.obi_req_i = 1'b0;
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL issue_timeout: no gnt for addr %h, got 0 want 1", addr);
        end
    endtask

    task automatic test_reset();
        bus.obi_req_i = 1'b0; bus.obi_we_i = 1'b0; bus.obi_addr_i = '0;
        bus.obi_be_i = 4'h0; bus.obi_wdata_i = '0;
`ifdef OBI_RREADY_EN
        bus.obi_rready_i = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #2;
        tests++; if (bus.obi_rvalid_o !== 1'b0) begin fails++; $display("FAIL reset_rvalid: got %b want 0", bus.obi_rvalid_o); end
        tests++; if (bus.obi_rdata_o !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", bus.obi_rdata_o); end
        tests++; if (bus.obi_err_o !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", bus.obi_err_o); end
        tests++; if (bus.obi_gnt_o !== 1'b0) begin fails++; $display("FAIL reset_gnt_idle: got %b want 0", bus.obi_gnt_o); end
        reset = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic test_write_read();
        issue(1'b1, 32'h10, 4'b1111, 32'hCAFE_F00D);
        tests++; if (g_we !== 1'b1) begin fails++; $display("FAIL sw_mem_we: got %b want 1", g_we); end
        tests++; if (g_a !== 32'h10) begin fails++; $display("FAIL sw_mem_a: got %h want 00000010", g_a); end
        issue(1'b0, 32'h10, 4'b1111, 32'h0);
        tests++; if (g_we !== 1'b0) begin fails++; $display("FAIL lw_mem_we: got %b want 0", g_we); end
        @(negedge clk);
        tests++; if (bus.obi_rvalid_o !== 1'b1) begin fails++; $display("FAIL lw_latency: rvalid got %b want 1", bus.obi_rvalid_o); end
        tests++; if (bus.obi_rdata_o !== 32'hCAFE_F00D) begin fails++; $display("FAIL lw_rdata: got %h want cafef00d", bus.obi_rdata_o); end
        @(posedge clk); #2;
    endtask

    task automatic test_byte_lanes();
        issue(1'b1, 32'h21, 4'b0010, 32'h0000_AB00);
        tests++; if (g_a !== 32'h21) begin fails++; $display("FAIL sb_mem_a: got %h want 00000021", g_a); end
        issue(1'b0, 32'h20, 4'b0010, 32'h0);
        tests++; if (g_a !== 32'h21) begin fails++; $display("FAIL lb_mem_a: got %h want 00000021", g_a); end
        @(negedge clk);
        tests++; if (bus.obi_rdata_o !== 32'h0000_AB00) begin fails++; $display("FAIL lb_rdata: got %h want 0000ab00", bus.obi_rdata_o); end
        @(posedge clk); #2;
    endtask

    task automatic test_halfword();
        issue(1'b1, 32'h30, 4'b1100, 32'h1234_0000);
        tests++; if (g_a !== 32'h32) begin fails++; $display("FAIL sh_mem_a: got %h want 00000032", g_a); end
        issue(1'b0, 32'h30, 4'b1100, 32'h0);
        @(negedge clk);
        tests++; if (bus.obi_rdata_o !== 32'h1234_0000) begin fails++; $display("FAIL lh_rdata: got %h want 12340000", bus.obi_rdata_o); end
        @(posedge clk); #2;
    endtask

    task automatic test_range_err();
        issue(1'b1, 32'h100, 4'b1111, 32'h5555_5555);
        tests++; if (g_we !== 1'b0) begin fails++; $display("FAIL range_mem_we: got %b want 0", g_we); end
        @(negedge clk);
        tests++; if (bus.obi_err_o !== 1'b1) begin fails++; $display("FAIL range_err: got %b want 1", bus.obi_err_o); end
        tests++; if (bus.obi_rdata_o !== 32'hDEAD_BEEF) begin fails++; $display("FAIL range_rdata: got %h want deadbeef", bus.obi_rdata_o); end
        @(posedge clk); #2;
        issue(1'b0, 32'h0, 4'b1111, 32'h0);
        @(negedge clk);
        tests++; if (bus.obi_rdata_o !== 32'h600D_F00D) begin fails++; $display("FAIL range_mem_intact: got %h want 600df00d", bus.obi_rdata_o); end
        @(posedge clk); #2;
    endtask

    task automatic test_illegal_be();
        issue(1'b0, 32'h40, 4'b0110, 32'h0);
        tests++; if (g_a !== 32'h40) begin fails++; $display("FAIL illegal_mem_a: got %h want 00000040", g_a); end
        @(negedge clk);
        tests++; if (bus.obi_err_o !== 1'b1) begin fails++; $display("FAIL illegal_err: got %b want 1", bus.obi_err_o); end
        tests++; if (bus.obi_rdata_o !== 32'hDEAD_BEEF) begin fails++; $display("FAIL illegal_rdata: got %h want deadbeef", bus.obi_rdata_o); end
        @(posedge clk); #2;
    endtask

`ifdef OBI_RREADY_EN
    task automatic test_backpressure();
        logic [31:0] addrs [3];
        logic [31:0] head_exp;
        rsp_t        r;
        int          grants = 0;
        addrs[0] = 32'h10; addrs[1] = 32'h30; addrs[2] = 32'h20;
        head_exp = 32'h0;
        bus.obi_rready_i = 1'b0;
        bus.obi_req_i = 1'b1; bus.obi_we_i = 1'b0; bus.obi_be_i = 4'b1111; bus.obi_addr_i = addrs[0];
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                tests++;
                if (bus.obi_rdata_o !== head_exp) begin fails++; $display("FAIL bp_head_stable: cycle %0d got %h want %h", c, bus.obi_rdata_o, head_exp); end
            end
            if (bus.obi_gnt_o) begin
                model(1'b0, bus.obi_addr_i, 4'b1111, 32'h0, r);
                sb.push_back(r);
                if (grants == 0) head_exp = r.rdata;
                grants++;
            end
            @(posedge clk); #2;
            if (grants < 3) bus.obi_addr_i = addrs[grants];
        end
        tests++; if (grants !== 2) begin fails++; $display("FAIL bp_grant_count: got %0d want 2", grants); end
        bus.obi_rready_i = 1'b1;
        @(negedge clk);
        tests++; if (bus.obi_gnt_o !== 1'b0) begin fails++; $display("FAIL bp_no_bypass: gnt got %b want 0", bus.obi_gnt_o); end
        @(posedge clk); #2;
        bus.obi_rready_i = 1'b0;
        @(negedge clk);
        tests++; if (bus.obi_gnt_o !== 1'b1) begin fails++; $display("FAIL bp_gnt_return: got %b want 1", bus.obi_gnt_o); end
        if (bus.obi_gnt_o) begin
            model(1'b0, bus.obi_addr_i, 4'b1111, 32'h0, r);
            sb.push_back(r);
        end
        @(posedge clk); #2;
        bus.obi_req_i = 1'b0;
        bus.obi_rready_i = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        tests++; if (sb.size() !== 0) begin fails++; $display("FAIL bp_drain: got %0d pending want 0", sb.size()); end
    endtask
`else
    task automatic test_gnt_always();
        rsp_t r;
        bus.obi_req_i = 1'b1; bus.obi_we_i = 1'b0; bus.obi_be_i = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            bus.obi_addr_i = (c % 2 == 0) ? 32'h10 : 32'h30;
            @(negedge clk);
            tests++; if (bus.obi_gnt_o !== 1'b1) begin fails++; $display("FAIL gnt_always: cycle %0d got %b want 1", c, bus.obi_gnt_o); end
            if (c > 0) begin
                tests++;
                if (bus.obi_rvalid_o !== 1'b1) begin fails++; $display("FAIL stream_rvalid: cycle %0d got %b want 1", c, bus.obi_rvalid_o); end
            end
            if (bus.obi_gnt_o) begin
                model(1'b0, bus.obi_addr_i, 4'b1111, 32'h0, r);
                sb.push_back(r);
            end
            @(posedge clk); #2;
        end
        bus.obi_req_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
    endtask
`endif

    task automatic test_reset_mid();
`ifdef OBI_RREADY_EN
        bus.obi_rready_i = 1'b0;
`endif
        issue(1'b0, 32'h10, 4'b1111, 32'h0);
        issue(1'b0, 32'h30, 4'b1111, 32'h0);
        @(negedge clk); #1;
        tests++; if (bus.obi_rvalid_o !== 1'b1) begin fails++; $display("FAIL mid_pre_rvalid: got %b want 1", bus.obi_rvalid_o); end
        reset = 1'b0;
        #1;
        tests++; if (bus.obi_rvalid_o !== 1'b0) begin fails++; $display("FAIL mid_async_rvalid: got %b want 0", bus.obi_rvalid_o); end
        tests++; if (bus.obi_rdata_o !== 32'h0) begin fails++; $display("FAIL mid_async_rdata: got %h want 0", bus.obi_rdata_o); end
        sb.delete();
        @(posedge clk); #2;
        reset = 1'b1;
`ifdef OBI_RREADY_EN
        bus.obi_rready_i = 1'b1;
`endif
        @(posedge clk); #2;
        issue(1'b0, 32'h10, 4'b1111, 32'h0);
        @(negedge clk);
        tests++; if (bus.obi_rvalid_o !== 1'b1) begin fails++; $display("FAIL post_reset_latency: rvalid got %b want 1", bus.obi_rvalid_o); end
        tests++; if (bus.obi_rdata_o !== 32'hCAFE_F00D) begin fails++; $display("FAIL post_reset_rdata: got %h want cafef00d", bus.obi_rdata_o); end
        @(posedge clk); #2;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem[0]     = 32'h600D_F00D;
        ref_mem[0] = 32'h600D_F00D;
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_halfword();
        test_range_err();
        test_illegal_be();
`ifdef OBI_RREADY_EN
        test_backpressure();
`else
        test_gnt_always();
`endif
        test_reset_mid();
        repeat (3) @(posedge clk);
        #2;
        tests++; if (sb.size() !== 0) begin fails++; $display("FAIL final_drain: got %0d pending want 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
